// File: rtl/hbm_write_port.sv
// AXI4 write initiator: streams a contiguous [start_addr, end_addr) region of
// DATA_WIDTH beats into HBM as INCR bursts of up to BURST_LEN beats, one in flight.
module hbm_write_port #(
    parameter int BURST_LEN  = 64,
    parameter int ID_WIDTH   = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [ADDR_WIDTH-1:0]   end_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);
    localparam int LEN_W     = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0]   rem_beats_q, rem_beats_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    error_q, error_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    awvalid_q, awvalid_d;

    logic [ADDR_WIDTH-1:0]   span_s;
    logic [ADDR_WIDTH-1:0]   req_beats_s;
    logic                    in_data_s;
    logic                    last_beat_s;
    logic                    w_hs_s;

    // Beats in the next burst: whole BURST_LEN, or whatever is left at the tail.
    function automatic logic [LEN_W-1:0] clip_len(input logic [ADDR_WIDTH-1:0] rem);
        logic [LEN_W-1:0] r;
        if (rem >= ADDR_WIDTH'(BURST_LEN)) begin
            r = LEN_W'(BURST_LEN);
        end else begin
            r = rem[LEN_W-1:0];
        end
        return r;
    endfunction

    // Request size in beats; an empty or inverted range means nothing to write.
    always_comb begin
        span_s      = end_addr - start_addr;
        req_beats_s = {ADDR_WIDTH{1'b0}};
        if (end_addr > start_addr) begin
            req_beats_s = span_s >> SIZE_LOG2;
        end else begin
            req_beats_s = {ADDR_WIDTH{1'b0}};
        end
    end

    assign in_data_s   = (state_q == ST_DATA);
    assign last_beat_s = (beat_cnt_q == (len_q - LEN_W'(1)));
    assign w_hs_s      = in_data_s && s_valid && m_axi_wready;

    // Next-state and datapath updates for the burst sequencer.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        rem_beats_d = rem_beats_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d  = start_addr;
                    rem_beats_d = req_beats_s;
                    error_d     = 1'b0;
                    if (req_beats_s == {ADDR_WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADDR;
                        len_d   = clip_len(req_beats_s);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (m_axi_awready) begin
                    state_d    = ST_DATA;
                    beat_cnt_d = {LEN_W{1'b0}};
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (w_hs_s) begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (last_beat_s) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    error_d     = error_q | m_axi_bresp[1];
                    rem_beats_d = rem_beats_q - ADDR_WIDTH'(len_q);
                    cur_addr_d  = cur_addr_q + (ADDR_WIDTH'(len_q) << SIZE_LOG2);
                    if (rem_beats_d == {ADDR_WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADDR;
                        len_d   = clip_len(rem_beats_d);
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d    = (state_d == ST_ADDR) || (state_d == ST_DATA) || (state_d == ST_RESP);
        done_d    = (state_d == ST_DONE);
        awvalid_d = (state_d == ST_ADDR);
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= {ADDR_WIDTH{1'b0}};
            rem_beats_q <= {ADDR_WIDTH{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            beat_cnt_q  <= {LEN_W{1'b0}};
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            awvalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            rem_beats_q <= rem_beats_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            awvalid_q   <= awvalid_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

    assign m_axi_awid    = {ID_WIDTH{1'b0}};
    assign m_axi_awaddr  = cur_addr_q;
    assign m_axi_awlen   = 8'(len_q - LEN_W'(1));
    assign m_axi_awsize  = 3'(SIZE_LOG2);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;

    // W channel is a straight pass-through of the stream while a burst's data phase is open.
    assign m_axi_wdata  = s_data;
    assign m_axi_wstrb  = {(DATA_WIDTH/8){1'b1}};
    assign m_axi_wvalid = in_data_s && s_valid;
    assign m_axi_wlast  = in_data_s && last_beat_s;
    assign s_ready      = in_data_s && m_axi_wready;
    assign m_axi_bready = (state_q == ST_RESP);

    assign m_axi_arid    = {ID_WIDTH{1'b0}};
    assign m_axi_araddr  = {ADDR_WIDTH{1'b0}};
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd0;
    assign m_axi_arburst = 2'd0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arvalid = 1'b0;
    assign m_axi_rready  = 1'b0;

    logic unused_s;
    assign unused_s = ^{m_axi_bid, m_axi_bresp[0], m_axi_arready, m_axi_rid,
                        m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid};

endmodule

// File: tb/tb_hbm_write_port.sv
// Directed bench for hbm_write_port: a bench-side AXI slave and stream source,
// with hand-computed burst layouts, beat counts and timing.
module tb_hbm_write_port;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   start_addr, end_addr;
    logic          busy, done, error;
    logic [255:0]  s_data;
    logic          s_valid, s_ready;
    logic [31:0]   awid, awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [255:0]  wdata;
    logic [31:0]   wstrb;
    logic          wlast, wvalid, wready;
    logic [31:0]   bid;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic [31:0]   arid, araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arlock;
    logic [3:0]    arcache;
    logic [2:0]    arprot;
    logic [3:0]    arqos;
    logic          arvalid, rready;

    hbm_write_port dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy), .done(done), .error(error),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
        .m_axi_arready(1'b0),
        .m_axi_rid(32'd0), .m_axi_rdata(256'd0), .m_axi_rresp(2'b00), .m_axi_rlast(1'b0),
        .m_axi_rvalid(1'b0), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int w_cnt, wlast_cnt, wlast_idx, b_cnt, done_cnt, done_cyc, busy_cyc;
    int data_bad, strb_bad, awattr_bad, extra_done, pend_b;
    logic err_at_done, err_after_start, busy_at_done, aw_seen, w_seen, timed_out;

    function automatic logic [255:0] beat_val(input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(k);
        return {8{w}};
    endfunction

    // Runs one transfer; cyc counts cycles after the start cycle (cyc=1 is the busy-rise cycle).
    task automatic run_xfer(input logic [31:0] sa, input logic [31:0] ea, input int toggle_sv,
                            input int stall_lo, input int stall_hi, input int err_burst,
                            input int rst_beat);
        logic fin;
        aw_addr_q.delete();
        aw_len_q.delete();
        w_cnt = 0; wlast_cnt = 0; wlast_idx = -1; b_cnt = 0; done_cnt = 0; done_cyc = 0;
        busy_cyc = 0; data_bad = 0; strb_bad = 0; awattr_bad = 0; extra_done = 0; pend_b = 0;
        err_at_done = 1'b0; err_after_start = 1'b1; busy_at_done = 1'b1;
        aw_seen = 1'b0; w_seen = 1'b0; timed_out = 1'b0; fin = 1'b0;
        @(negedge clk);
        start_addr = sa; end_addr = ea; start = 1'b1;
        for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
            @(negedge clk);
            start   = 1'b0;
            s_valid = (toggle_sv != 0) ? 1'(cyc % 2) : 1'b1;
            s_data  = beat_val(w_cnt);
            wready  = !(cyc >= stall_lo && cyc <= stall_hi);
            awready = 1'b1;
            bvalid  = (pend_b > 0);
            bresp   = (bvalid && b_cnt == err_burst) ? 2'b10 : 2'b00;
            rst     = (rst_beat >= 0 && w_cnt == rst_beat);
            #1;
            if (cyc == 1) err_after_start = error;
            if (rst) begin
                fin = 1'b1;
            end else begin
                if (busy) busy_cyc++;
                if (awvalid) aw_seen = 1'b1;
                if (wvalid) w_seen = 1'b1;
                if (awvalid && awready) begin
                    aw_addr_q.push_back(awaddr);
                    aw_len_q.push_back(awlen);
                    if (awsize != 3'd5 || awburst != 2'b01 || awid != 32'd0) awattr_bad++;
                end
                if (wvalid && wready) begin
                    if (wdata !== beat_val(w_cnt)) data_bad++;
                    if (wstrb !== 32'hFFFF_FFFF) strb_bad++;
                    if (wlast) begin
                        wlast_cnt++;
                        wlast_idx = w_cnt;
                        pend_b++;
                    end
                    w_cnt++;
                end
                if (bvalid && bready) begin
                    b_cnt++;
                    pend_b--;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc     = cyc;
                    err_at_done  = error;
                    busy_at_done = busy;
                    fin          = 1'b1;
                end
            end
        end
        if (!fin) timed_out = 1'b1;
        if (rst_beat < 0) begin
            bvalid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                if (done) extra_done++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = 32'd0; end_addr = 32'd0;
        s_data = 256'd0; s_valid = 1'b0; awready = 1'b0; wready = 1'b0;
        bid = 32'd0; bresp = 2'b00; bvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_outputs", {busy, done, error, awvalid, wvalid, wlast, bready, s_ready}, 64'h0);
        check_val("ar_tied_zero", {arvalid, rready, araddr, arlen, arid}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // 64 beats, single full burst
        run_xfer(32'h0, 32'h800, 0, 0, -1, -1, -1);
        check_val("t1_timeout", timed_out, 0);
        check_val("t1_aw_count", aw_addr_q.size(), 1);
        check_val("t1_awaddr", aw_addr_q[0], 32'h0);
        check_val("t1_awlen", aw_len_q[0], 8'd63);
        check_val("t1_awattr", awattr_bad, 0);
        check_val("t1_w_beats", w_cnt, 64);
        check_val("t1_wlast_idx", wlast_idx, 63);
        check_val("t1_wlast_count", wlast_cnt, 1);
        check_val("t1_b_count", b_cnt, 1);
        check_val("t1_busy_cycles", busy_cyc, 66);
        check_val("t1_busy_rise_to_done", done_cyc, 67);
        check_val("t1_busy_at_done", busy_at_done, 0);
        check_val("t1_error", err_at_done, 0);
        check_val("t1_single_done", extra_done, 0);
        check_val("t1_wdata", data_bad, 0);
        check_val("t1_wstrb", strb_bad, 0);

        // 150 beats -> 64 + 64 + 22
        run_xfer(32'h1000, 32'h1000 + 32'd150 * 32'd32, 0, 0, -1, -1, -1);
        check_val("t2_timeout", timed_out, 0);
        check_val("t2_aw_count", aw_addr_q.size(), 3);
        check_val("t2_awaddr0", aw_addr_q[0], 32'h1000);
        check_val("t2_awlen0", aw_len_q[0], 8'd63);
        check_val("t2_awaddr1", aw_addr_q[1], 32'h1800);
        check_val("t2_awlen1", aw_len_q[1], 8'd63);
        check_val("t2_awaddr2", aw_addr_q[2], 32'h2000);
        check_val("t2_awlen2", aw_len_q[2], 8'd21);
        check_val("t2_w_beats", w_cnt, 150);
        check_val("t2_wlast_count", wlast_cnt, 3);
        check_val("t2_b_count", b_cnt, 3);
        check_val("t2_done", done_cnt, 1);
        check_val("t2_wdata", data_bad, 0);

        // empty range: done in the cycle right after the start cycle, no AXI traffic
        run_xfer(32'h40, 32'h40, 0, 0, -1, -1, -1);
        check_val("t3_timeout", timed_out, 0);
        check_val("t3_done_cyc", done_cyc, 1);
        check_val("t3_no_aw", aw_seen, 0);
        check_val("t3_no_w", w_seen, 0);
        check_val("t3_single_done", extra_done, 0);

        // inverted range behaves as empty
        run_xfer(32'h100, 32'h80, 0, 0, -1, -1, -1);
        check_val("t3b_done_cyc", done_cyc, 1);
        check_val("t3b_no_aw", aw_seen, 0);

        // 8 beats, s_valid toggling, wready low on cycles 4..6
        run_xfer(32'h4000, 32'h4100, 1, 4, 6, -1, -1);
        check_val("t4_timeout", timed_out, 0);
        check_val("t4_awlen", aw_len_q[0], 8'd7);
        check_val("t4_w_beats", w_cnt, 8);
        check_val("t4_wlast_idx", wlast_idx, 7);
        check_val("t4_wlast_count", wlast_cnt, 1);
        check_val("t4_wdata_order", data_bad, 0);
        check_val("t4_done", done_cnt, 1);

        // 70 beats (64 + 6), second B returns SLVERR
        run_xfer(32'h8000, 32'h8000 + 32'd70 * 32'd32, 0, 0, -1, 1, -1);
        check_val("t5_timeout", timed_out, 0);
        check_val("t5_awlen1", aw_len_q[1], 8'd5);
        check_val("t5_awaddr1", aw_addr_q[1], 32'h8800);
        check_val("t5_error_at_done", err_at_done, 1);
        check_val("t5_error_sticky", error, 1);

        // 64-beat burst reset during beat 10; start also clears the sticky error
        run_xfer(32'h0, 32'h800, 0, 0, -1, -1, 10);
        check_val("t6_error_cleared_on_start", err_after_start, 0);
        check_val("t6_beats_before_rst", w_cnt, 10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("t6_rst_outputs", {busy, done, error, awvalid, wvalid, wlast, bready, s_ready}, 64'h0);
        run_xfer(32'h3000, 32'h3080, 0, 0, -1, -1, -1);
        check_val("t6_timeout", timed_out, 0);
        check_val("t6_new_awaddr", aw_addr_q[0], 32'h3000);
        check_val("t6_new_awlen", aw_len_q[0], 8'd3);
        check_val("t6_new_w_beats", w_cnt, 4);
        check_val("t6_new_done", done_cnt, 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
